// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding
// (matches the transmitter's selector) and the supported prescale ratios.
package uart_rx_pkg;

    localparam int PRESCALE_W = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [PRESCALE_W-1:0] PRESCALE_8       = 6'd8;
    localparam logic [PRESCALE_W-1:0] PRESCALE_16      = 6'd16;
    localparam logic [PRESCALE_W-1:0] PRESCALE_32      = 6'd32;
    localparam logic [PRESCALE_W-1:0] PRESCALE_DEFAULT = PRESCALE_8;

    // Unsupported ratios fall back to the default so edge_cnt always wraps sanely.
    function automatic logic [PRESCALE_W-1:0] legal_prescale(input logic [PRESCALE_W-1:0] p);
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
            default:                              return PRESCALE_DEFAULT;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line plus frame configuration in, parallel
// word and status pulses out. The receiver uses the slave modport.
interface uart_rx_if #(parameter int DATA_WIDTH = 8);
    import uart_rx_pkg::*;

    logic                  rx_in;
    logic                  par_en;
    logic                  par_typ;
    logic [PRESCALE_W-1:0] prescale;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport master (
        output rx_in, par_en, par_typ, prescale,
        input  p_data, data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  rx_in, par_en, par_typ, prescale,
        output p_data, data_valid, par_err, stp_err, busy
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with a 3-sample mid-bit majority vote; strobes
// the decision cycle and the last cycle of each bit period.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  rx_s,
    output logic                  bit_val,
    output logic                  sample_stb,
    output logic                  bit_end
);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic [2:0]            samples;

    assign half       = {1'b0, prescale[PRESCALE_W-1:1]};
    assign bit_end    = run && (edge_cnt == prescale - 6'd1);
    assign sample_stb = run && (edge_cnt == half + 6'd1);
    assign bit_val    = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                        (samples[1] & samples[2]);

    // The counter idles at 0 so the first bit period starts cleanly on entry to START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            samples  <= '0;
        end else begin
            if (!run || bit_end)
                edge_cnt <= '0;
            else
                edge_cnt <= edge_cnt + 6'd1;

            if (run) begin
                if (edge_cnt == half - 6'd2) samples[0] <= rx_s;
                if (edge_cnt == half - 6'd1) samples[1] <= rx_s;
                if (edge_cnt == half)        samples[2] <= rx_s;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: input synchroniser, frame FSM, LSB-first deserialiser,
// parity/stop checking and one-cycle result pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    uart_rx_if.slave bus
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   start_edge;

    state_t state, next_state;

    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_flag;

    logic bit_val;
    logic sample_stb;
    logic bit_end;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign start_edge = rx_prev & ~rx_s;
    assign bus.busy   = (state != IDLE);

    // Synchroniser resets to the idle-line level so no false start appears after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.rx_in};
            rx_prev <= rx_s;
        end
    end

    uart_rx_sampler u_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (state != IDLE),
        .prescale   (prescale_q),
        .rx_s       (rx_s),
        .bit_val    (bit_val),
        .sample_stb (sample_stb),
        .bit_end    (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // STOP leaves at the decision cycle so a back-to-back start edge is not missed.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_edge) next_state = START;
            START: begin
                if (sample_stb && bit_val) next_state = IDLE;
                else if (bit_end)          next_state = DATA;
            end
            DATA:    if (bit_end && bit_cnt == LAST_BIT) next_state = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) next_state = STOP;
            STOP:    if (sample_stb) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q <= PRESCALE_DEFAULT;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            par_flag   <= 1'b0;
        end else begin
            if (state == IDLE && start_edge) begin
                prescale_q <= legal_prescale(bus.prescale);
                par_en_q   <= bus.par_en;
                par_typ_q  <= bus.par_typ;
                bit_cnt    <= '0;
                par_flag   <= 1'b0;
            end
            if (state == DATA) begin
                if (sample_stb)
                    shift_q <= DATA_WIDTH'({bit_val, shift_q} >> 1);
                if (bit_end)
                    bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
            end
            if (state == PARITY && sample_stb)
                par_flag <= (bit_val != (^shift_q ^ par_typ_q));
        end
    end

    // Stop error outranks parity error; only a clean frame updates p_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.p_data     <= '0;
            bus.data_valid <= 1'b0;
            bus.par_err    <= 1'b0;
            bus.stp_err    <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            bus.par_err    <= 1'b0;
            bus.stp_err    <= 1'b0;
            if (state == STOP && sample_stb) begin
                if (!bit_val)
                    bus.stp_err <= 1'b1;
                else if (par_flag)
                    bus.par_err <= 1'b1;
                else begin
                    bus.p_data     <= shift_q;
                    bus.data_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frames against a frame-level outcome model
// (valid / parity error / stop error, expected word and latency).
module tb_uart_rx;

    localparam int DW = 8;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if #(.DATA_WIDTH(DW)) bus();

    uart_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int assert_count = 0;
    int fail_count   = 0;
    int cyc          = 0;
    int start_cyc    = 0;
    int valid_cnt    = 0;
    int par_cnt      = 0;
    int stp_cnt      = 0;
    int long_pulse   = 0;
    int valid_cyc    = 0;
    logic prev_pulse = 1'b0;
    logic [DW-1:0] valid_q[$];
    logic [DW-1:0] exp_pdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts every status pulse and flags any lasting two cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pulse = 1'b0;
        end else begin
            if (bus.data_valid) begin
                valid_cnt++;
                valid_q.push_back(bus.p_data);
                valid_cyc = cyc;
            end
            if (bus.par_err) par_cnt++;
            if (bus.stp_err) stp_cnt++;
            if ((bus.data_valid | bus.par_err | bus.stp_err) && prev_pulse) long_pulse++;
            prev_pulse = bus.data_valid | bus.par_err | bus.stp_err;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkRange(input string tag, input int obs, input int lo, input int hi);
        assert_count++;
        assert (obs >= lo && obs <= hi) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic driveBit(input logic b, input int len, input int glitch_at);
        for (int c = 0; c < len; c++) begin
            bus.rx_in = (c == glitch_at) ? ~b : b;
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic [5:0] ps, input int bl,
                                 input logic pe, input logic pt, input logic par_bit,
                                 input logic stop_bit, input int glitch_bit, input int idle);
        bus.prescale = ps;
        bus.par_en   = pe;
        bus.par_typ  = pt;
        start_cyc    = cyc;
        driveBit(1'b0, bl, -1);
        for (int i = 0; i < DW; i++)
            driveBit(data[i], bl, (i == glitch_bit) ? bl / 2 : -1);
        if (pe) driveBit(par_bit, bl, -1);
        driveBit(stop_bit, bl, -1);
        bus.rx_in = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    // Outcome model: 0 = word delivered, 1 = parity error, 2 = stop error.
    task automatic runFrame(input string tag, input logic [7:0] data, input logic [5:0] ps,
                            input int bl, input logic pe, input logic pt, input logic par_bit,
                            input logic stop_bit, input int glitch_bit);
        int v0 = valid_cnt;
        int p0 = par_cnt;
        int s0 = stp_cnt;
        int outcome;
        int lat;
        int exp_lat;
        if (!stop_bit)                                    outcome = 2;
        else if (pe && (par_bit != ((^data) ^ pt)))       outcome = 1;
        else                                              outcome = 0;
        applyStimulus(data, ps, bl, pe, pt, par_bit, stop_bit, glitch_bit, bl + 4);
        checkOutput({tag, " valid"}, 32'(valid_cnt - v0), (outcome == 0) ? 32'd1 : 32'd0);
        checkOutput({tag, " par_err"}, 32'(par_cnt - p0), (outcome == 1) ? 32'd1 : 32'd0);
        checkOutput({tag, " stp_err"}, 32'(stp_cnt - s0), (outcome == 2) ? 32'd1 : 32'd0);
        if (outcome == 0) begin
            exp_pdata = data;
            lat = valid_cyc - start_cyc - 1;
            exp_lat = SS + (1 + DW + int'(pe)) * bl + bl / 2 + 2;
            checkRange({tag, " latency"}, lat, exp_lat - 1, exp_lat + 1);
        end
        checkOutput({tag, " p_data"}, 32'(bus.p_data), 32'(exp_pdata));
        checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int v0;
        int p0;
        int s0;
        int n0;
        logic [7:0] d;
        int bl;
        logic pe;
        logic pt;
        logic pb;
        logic sb;

        bus.rx_in    = 1'b1;
        bus.prescale = 6'd8;
        bus.par_en   = 1'b0;
        bus.par_typ  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset p_data", 32'(bus.p_data), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset valid", 32'(bus.data_valid), 32'd0);
        checkOutput("reset errs", 32'({bus.par_err, bus.stp_err}), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post-reset busy", 32'(bus.busy), 32'd0);

        runFrame("basic A5", 8'hA5, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        runFrame("even 3C ok", 8'h3C, 6'd16, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        runFrame("even 3C bad", 8'h3C, 6'd16, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        runFrame("stop err 81", 8'h81, 6'd32, 32, 1'b0, 1'b0, 1'b0, 1'b0, -1);

        // Short start glitch: FSM briefly leaves IDLE, then rejects it.
        v0 = valid_cnt; p0 = par_cnt; s0 = stp_cnt;
        bus.prescale = 6'd16;
        bus.rx_in = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("glitch busy high", 32'(bus.busy), 32'd1);
        bus.rx_in = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("glitch busy low", 32'(bus.busy), 32'd0);
        checkOutput("glitch pulses", 32'((valid_cnt - v0) + (par_cnt - p0) + (stp_cnt - s0)), 32'd0);

        runFrame("vote 55", 8'h55, 6'd16, 16, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        // Back-to-back frames with no idle gap.
        n0 = valid_q.size();
        applyStimulus(8'h01, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        applyStimulus(8'hFE, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 12);
        exp_pdata = 8'hFE;
        checkOutput("b2b count", 32'(valid_q.size() - n0), 32'd2);
        if (valid_q.size() >= n0 + 2) begin
            checkOutput("b2b first", 32'(valid_q[n0]), 32'h01);
            checkOutput("b2b second", 32'(valid_q[n0 + 1]), 32'hFE);
        end
        checkOutput("b2b p_data", 32'(bus.p_data), 32'(exp_pdata));

        runFrame("illegal ps", 8'h6B, 6'd20, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);

        // Break: line held low through and past a whole frame.
        v0 = valid_cnt; s0 = stp_cnt;
        bus.prescale = 6'd8;
        bus.par_en = 1'b0;
        bus.rx_in = 1'b0;
        repeat (10 * 8 + 24) @(negedge clk);
        checkOutput("break stp_err", 32'(stp_cnt - s0), 32'd1);
        checkOutput("break idle", 32'(bus.busy), 32'd0);
        bus.rx_in = 1'b1;
        repeat (16) @(negedge clk);
        checkOutput("break valid", 32'(valid_cnt - v0), 32'd0);
        checkOutput("break p_data", 32'(bus.p_data), 32'(exp_pdata));

        // Reset during data bit 4 of 0xF0.
        v0 = valid_cnt; p0 = par_cnt; s0 = stp_cnt;
        d = 8'hF0;
        bus.rx_in = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx_in = d[i];
            repeat (8) @(negedge clk);
        end
        bus.rx_in = d[4];
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        bus.rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_pdata = '0;
        repeat (40) @(negedge clk);
        checkOutput("abort pulses", 32'((valid_cnt - v0) + (par_cnt - p0) + (stp_cnt - s0)), 32'd0);
        checkOutput("abort p_data", 32'(bus.p_data), 32'd0);
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        runFrame("after abort 12", 8'h12, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);

        for (int n = 0; n < 12; n++) begin
            d  = 8'($urandom);
            bl = 8 << $urandom_range(0, 2);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            pb = (^d) ^ pt ^ ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 5) != 0);
            runFrame("random", d, 6'(bl), bl, pe, pt, pb, sb, -1);
        end

        checkOutput("pulse width", 32'(long_pulse), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver. It is the receive-side counterpart of the UART V3 transmitter (start/data/parity/stop framing, line idle high).
- Oversamples RX_IN using a per-frame prescale value and takes a 3-sample majority vote at mid-bit.
- Deserialises the frame LSB first.
- Checks parity and the stop bit, then presents a parallel word with a one-cycle valid pulse.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- SYNC_STAGES, 2, number of flops in the RX_IN synchroniser (minimum 2).

Ports:
- CLK  input  1  receiver clock (oversampling clock).
- RST  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line; idle high; asynchronous to CLK.
- PAR_EN  input  1  1 = a parity bit follows the data bits.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- PRESCALE  input  6  oversampling ratio; legal values 8, 16, 32.
- P_DATA  output  DATA_WIDTH  last correctly received word.
- DATA_VALID  output  1  one-cycle pulse; P_DATA updated this cycle.
- PAR_ERR  output  1  one-cycle pulse; parity mismatch, frame discarded.
- STP_ERR  output  1  one-cycle pulse; stop bit sampled as 0, frame discarded.
- BUSY  output  1  high while in any state other than IDLE.

Behaviour:
- Reset (RST low, asynchronous): P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, BUSY=0. FSM goes to IDLE, all counters clear to 0, synchroniser flops set to 1.
- Reset asserted mid-frame aborts the frame. No pulses are issued and P_DATA keeps its reset value of 0.
- RX_IN passes through SYNC_STAGES flops. Everything below uses the synchronised signal rx_s.
- PRESCALE and PAR_EN/PAR_TYP are latched on the IDLE→START transition and held for the whole frame.
- A latched PRESCALE value other than 8, 16 or 32 is treated as 8.
- Let P be the latched prescale.
  - edge_cnt runs 0..P-1 per bit and wraps to 0 at P-1.
  - bit_cnt counts data bits, 0..DATA_WIDTH-1.
- Sampling:
  - rx_s is captured at edge_cnt = P/2-2, P/2-1 and P/2.
  - The bit value is the majority of the three samples, valid from edge_cnt = P/2+1 (the "decision cycle").
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Falling edge on rx_s (1 then 0) → START, with edge_cnt=0.
- START:
  - At the decision cycle, majority = 1 is a glitch: return to IDLE with no pulses.
  - Otherwise continue. At edge_cnt = P-1 → DATA.
- DATA:
  - At each decision cycle, the bit is shifted into a shift register, LSB first.
  - At edge_cnt = P-1 with bit_cnt = DATA_WIDTH-1 → PARITY if PAR_EN, else → STOP.
- PARITY:
  - At the decision cycle, compare the sampled bit with the computed parity of the data bits.
  - Expected bit = XOR of data bits XOR PAR_TYP.
  - The mismatch result is stored in a flag. At edge_cnt = P-1 → STOP.
- STOP:
  - At the decision cycle, return to IDLE immediately. The remaining half bit is not waited out, so a back-to-back start edge is caught.
  - In the cycle after the STOP decision, exactly one of these outcomes applies:
    - If the stop bit sampled 0: STP_ERR=1 for one cycle, DATA_VALID=0, P_DATA unchanged. STP_ERR takes priority over PAR_ERR.
    - Else if the parity flag is set: PAR_ERR=1 for one cycle, DATA_VALID=0, P_DATA unchanged.
    - Else: P_DATA is loaded from the shift register and DATA_VALID=1 for one cycle.
- BUSY follows the FSM state: high in any state except IDLE.
- Pulses never last more than one cycle and never overlap between consecutive frames.
- rx_s held low for the entire frame (break condition) gives STP_ERR. The FSM then stays in IDLE until rx_s returns to 1 and a new falling edge occurs.
- Latency: DATA_VALID asserts SYNC_STAGES + (1 + DATA_WIDTH + PAR_EN)·P + P/2 + 2 cycles after the RX_IN falling edge. The bench checks this with a tolerance of ±1 cycle.

Decomposition:
- Package uart_rx_pkg holds:
  - the FSM state enum (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; same encoding as the TX selector);
  - the legal prescale constants 8, 16, 32;
  - the default prescale constant 8.
- Sub-module uart_rx_sampler contains edge_cnt, the 3-sample capture, the majority vote and the decision-cycle strobe.
- The top level holds the FSM, bit_cnt, shift register, parity and output registers.

Test Plan:
- Basic frame: PRESCALE=8, PAR_EN=0, send 0xA5 → DATA_VALID pulses once, P_DATA=0xA5, no error pulses, BUSY returns to 0.
- Even parity: PRESCALE=16, PAR_EN=1, PAR_TYP=0.
  - Send 0x3C with parity bit 0 → DATA_VALID, P_DATA=0x3C.
  - Resend 0x3C with parity bit 1 → PAR_ERR pulse, P_DATA stays 0x3C.
- Stop error: PRESCALE=32, send 0x81 with stop bit 0 → STP_ERR pulse, no DATA_VALID, P_DATA unchanged.
- Start glitch and majority vote:
  - A low pulse of 3 clocks at PRESCALE=16 → no BUSY beyond the start bit, no pulses.
  - A single-clock inverted glitch at the mid-sample of data bit 2 of 0x55 → P_DATA=0x55.
- Back-to-back frames: 0x01 then 0xFE, with the second start bit immediately after the first stop bit at PRESCALE=8 → two DATA_VALID pulses, values in order.
- Reset mid-frame: RST low during data bit 4 of 0xF0, then a clean 0x12 frame → no pulse for the aborted frame, then DATA_VALID with P_DATA=0x12.
